// File: rtl/useq_stack_pkg.sv
// Shared microsequencer stack definitions: default sizes and the per-microcycle
// stack action decoded from the CROM CALL bit and the RETURN dispatch.
package useq_stack_pkg;

  localparam int unsigned USEQ_ADDR_WIDTH  = 12;
  localparam int unsigned USEQ_STACK_DEPTH = 16;
  localparam int unsigned USEQ_PTR_WIDTH   = $clog2(USEQ_STACK_DEPTH);

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'b00,
    ACT_POP     = 2'b01,
    ACT_PUSH    = 2'b10,
    ACT_REPLACE = 2'b11
  } stack_act_e;

  // {call, ret} maps directly onto the action encoding
  function automatic stack_act_e decode_act(input logic call, input logic ret);
    return stack_act_e'({call, ret});
  endfunction

endpackage

// File: rtl/useq_stack_ram.sv
// Stack entry register file: one write port, two asynchronous read ports
// (top of stack and diagnostic), contents cleared by reset.
module useq_stack_ram
  import useq_stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = USEQ_ADDR_WIDTH,
  parameter int unsigned DEPTH      = USEQ_STACK_DEPTH,
  parameter int unsigned PTR_WIDTH  = USEQ_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [PTR_WIDTH-1:0]  waddr_i,
  input  logic [ADDR_WIDTH-1:0] wdata_i,
  input  logic [PTR_WIDTH-1:0]  top_addr_i,
  output logic [ADDR_WIDTH-1:0] top_data_o,
  input  logic [PTR_WIDTH-1:0]  diag_addr_i,
  output logic [ADDR_WIDTH-1:0] diag_data_o
);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign top_data_o  = mem_q[top_addr_i];
  assign diag_data_o = mem_q[diag_addr_i];

endmodule

// File: rtl/useq_stack.sv
// Microsequencer call/return stack: circular buffer with saturating count,
// sticky overflow/underflow flags and a top-relative diagnostic read port.
module useq_stack
  import useq_stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = USEQ_ADDR_WIDTH,
  parameter int unsigned DEPTH      = USEQ_STACK_DEPTH,
  parameter int unsigned PTR_WIDTH  = USEQ_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  call,
  input  logic                  ret,
  input  logic [ADDR_WIDTH-1:0] pushADDR,
  input  logic                  clrFLAGS,
  input  logic [PTR_WIDTH-1:0]  diagSEL,
  output logic [ADDR_WIDTH-1:0] dispRET,
  output logic [ADDR_WIDTH-1:0] diagDATA,
  output logic [PTR_WIDTH:0]    depth,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0]  sp_q, sp_d, sp_m1;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  empty, full;
  stack_act_e            act;

  logic                  we;
  logic [PTR_WIDTH-1:0]  waddr, diag_addr;
  logic [ADDR_WIDTH-1:0] top_data, diag_data;

  assign sp_m1     = sp_q - PTR_WIDTH'(1);
  assign diag_addr = sp_m1 - diagSEL;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));

  // Next-state for pointer, count and flags; clrFLAGS is overridden by a same-cycle set
  always_comb begin
    act     = clken ? decode_act(call, ret) : ACT_HOLD;
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = (clken && clrFLAGS) ? 1'b0 : ovf_q;
    unf_d   = (clken && clrFLAGS) ? 1'b0 : unf_q;
    we      = 1'b0;
    waddr   = sp_q;

    case (act)
      ACT_PUSH: begin
        we   = 1'b1;
        sp_d = sp_q + PTR_WIDTH'(1);
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ACT_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d    = sp_m1;
          count_d = count_q - CNT_W'(1);
        end
      end
      ACT_REPLACE: begin
        we = 1'b1;
        if (empty) begin
          sp_d    = sp_q + PTR_WIDTH'(1);
          count_d = CNT_W'(1);
          unf_d   = 1'b1;
        end else begin
          waddr = sp_m1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  useq_stack_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_ram (
    .clk         (clk),
    .rst_n       (rst),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (pushADDR),
    .top_addr_i  (sp_m1),
    .top_data_o  (top_data),
    .diag_addr_i (diag_addr),
    .diag_data_o (diag_data)
  );

  // Empty stack forces the dispatch RET address to zero
  assign dispRET   = empty ? '0 : top_data;
  assign diagDATA  = diag_data;
  assign depth     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/useq_stack.md
Name: useq_stack

Overview:
- Microsequencer call/return stack.
- Sits directly upstream of the microcode dispatch multiplexer: supplies the 12-bit return address driven onto the dispatch RET input (`dispRET[0:11]`).
- On a microcode CALL it pushes the caller-supplied return address; on a microcode RETURN dispatch it pops.
- Implemented as a circular buffer of flops, with overflow/underflow detection and a diagnostic read port.

Parameters:
- ADDR_WIDTH, 12, microcode address width (bits 0:11, MSB-first numbering).
- DEPTH, 16, number of stack entries; must be a power of two, 4..64.
- PTR_WIDTH, 4, log2(DEPTH); must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clken  in  1  microcycle enable; no state changes when low.
- call  in  1  push request (decoded CROM CALL bit).
- ret  in  1  pop request (CROM DISP = RETURN).
- pushADDR  in  [0:ADDR_WIDTH-1]  return address to push (current micro-PC + 1, formed upstream).
- clrFLAGS  in  1  synchronous clear of the sticky error flags (qualified by clken).
- diagSEL  in  [0:PTR_WIDTH-1]  diagnostic entry index, relative to the top of stack.
- dispRET  out  [0:ADDR_WIDTH-1]  top-of-stack value, to the dispatch RET select.
- diagDATA  out  [0:ADDR_WIDTH-1]  entry at (top − diagSEL).
- depth  out  [0:PTR_WIDTH]  number of valid entries, 0..DEPTH.
- overflow  out  1  sticky: a push occurred while full.
- underflow  out  1  sticky: a pop occurred while empty.

Behaviour:
- **Reset (rst low, asynchronous):**
  - sp=0, count=0, overflow=0, underflow=0, all entries=0.
  - Hence dispRET=0, diagDATA=0, depth=0.
  - Reset may assert mid-cycle; outputs go to reset values immediately, with no clock required.
- **State:** entry array mem[0:DEPTH-1], write pointer sp (PTR_WIDTH bits, wraps modulo DEPTH), count (PTR_WIDTH+1 bits, saturating at DEPTH).
- **Outputs:**
  - dispRET = mem[sp−1 mod DEPTH] when count>0, else 0.
  - dispRET is a direct read of registered state: valid in the same cycle the dispatch mux samples it, with zero added latency.
- **Actions**, evaluated at the rising edge only when clken=1:
  - **call=1, ret=0 (push):** mem[sp]←pushADDR; sp←sp+1.
    - count<DEPTH: count←count+1.
    - Full: count stays DEPTH, the oldest entry is overwritten (ring wrap), overflow←1.
  - **ret=1, call=0 (pop):**
    - count>0: sp←sp−1, count←count−1.
    - count=0: sp and count unchanged, underflow←1. dispRET=0 during that cycle, so the dispatch goes to address 0 in the low bits.
  - **call=1, ret=1 (replace):**
    - The RET dispatch consumes the current top, and the new address takes its place.
    - count>0: mem[sp−1]←pushADDR; sp and count unchanged.
    - count=0: treated as a push (mem[sp]←pushADDR, sp+1, count=1), and underflow←1.
  - **Neither:** hold.
- **Flags:**
  - clrFLAGS=1 clears both flags.
  - If an error condition occurs in the same cycle, the set wins.
- **Timing:** new dispRET is visible one clock after the push/pop edge. Results of a push are readable by a RET in the immediately following microcycle.
- **clken=0:** all inputs are ignored, including clrFLAGS.
- **Diagnostic read:**
  - diagDATA = mem[(sp−1−diagSEL) mod DEPTH], purely combinational from state.
  - Entries beyond count return stale contents; this is by design for the diagnostic path.
- **Arithmetic:** all pointer math is modulo DEPTH; there are no X-propagating reads.

Decomposition:
- Shared package/header (useq.vh):
  - USEQ_ADDR_WIDTH=12, USEQ_STACK_DEPTH=16.
  - Macro for the CROM CALL bit and the DISP RETURN encoding, reused by the dispatch block.
- One sub-module, useq_stack_ram: DEPTH×ADDR_WIDTH register file.
  - Write port: we, waddr, wdata.
  - Two asynchronous read ports: top and diag.
  - Async-reset to 0.
- useq_stack holds the pointer/count/flag control around useq_stack_ram.

Test Plan:
- Reset then idle: rst low with clken=1 → dispRET=0, depth=0, overflow=0, underflow=0; hold over 5 clocks unchanged.
- Push 12'o0100, 12'o0200, 12'o0300 → depth=3, dispRET=12'o0300. Pop → 12'o0200; pop → 12'o0100; pop → depth=0, dispRET=0, no flags.
- Push 17 values 12'o1000..12'o1020 (DEPTH=16) → overflow=1, depth=16, dispRET=12'o1020. Pop 16 times in order → 12'o1020..12'o1001; the next pop gives underflow=1.
- Pop on empty → underflow=1, dispRET=0, depth=0. clrFLAGS together with a second empty pop → underflow stays 1. clrFLAGS alone → underflow=0.
- Simultaneous call+ret:
  - With top=12'o0200, depth=2, pushADDR=12'o7777 → dispRET=12'o7777, depth=2, then pop → previous entry.
  - On empty → depth=1, underflow=1.
- clken=0 with call/ret/clrFLAGS asserted → no state change. Assert rst mid-sequence at depth=5, off-edge → all outputs zero immediately. diagSEL=0..2 after pushes A,B,C → C,B,A.
